ccp_tag_bank_arbiter: RTL and testbench
=======================================

// Module: ccp_tag_bank_arbiter
// PURPOSE
//  Sequences and shares the banked CCP tag SRAMs between a lookup (read) port and an update (write) port.
//  Maps set->bank, arbitrates per bank, drives chip_en/write_en/mask/address/data_in, returns read data.
//  After reset, runs a zero-fill of every set before accepting traffic.
//  Sits between the CCP pipeline and the tag-bank SRAM wrappers.
// PARAMETERS
//  N_SETS           1024  total sets; power of 2
//  N_TAG_BANKS      2     tag banks; power of 2, >=1
//  N_WAYS           2     ways per set
//  TAG_W            25    tag bits per way (TAG_PER_WAY_DATA_W)
//  SET_W            $clog2(N_SETS)                   derived
//  BNK_W            $clog2(N_TAG_BANKS)              derived, 0 when N_TAG_BANKS==1
//  SET_PER_BANK_W   $clog2(N_SETS/N_TAG_BANKS)       derived
// PORTS
//  clk                 in   1                   clock
//  reset               in   1                   synchronous, active-high
//  lkp_valid           in   1                   lookup request
//  lkp_ready           out  1                   lookup accepted this cycle when valid&ready
//  lkp_set             in   SET_W               lookup set index
//  rsp_valid           out  1                   lookup data valid; no backpressure
//  rsp_data            out  N_WAYS*TAG_W        all ways of the looked-up set
//  upd_valid           in   1                   update request
//  upd_ready           out  1                   update accepted when valid&ready
//  upd_set             in   SET_W               update set index
//  upd_way_mask        in   N_WAYS              ways to write
//  upd_data            in   N_WAYS*TAG_W        per-way write data; way i at [i*TAG_W +: TAG_W]
//  init_done           out  1                   zero-fill complete
//  tag_mem_chip_en     out  N_TAG_BANKS         per-bank enable
//  tag_mem_write_en    out  N_TAG_BANKS         per-bank write
//  tag_mem_write_en_mask out N_TAG_BANKS*N_WAYS per-bank way mask
//  tag_mem_address     out  N_TAG_BANKS*SET_PER_BANK_W  per-bank set address
//  tag_mem_data_in     out  N_TAG_BANKS*N_WAYS*TAG_W    per-bank write data
//  tag_mem_data_out    in   N_TAG_BANKS*N_WAYS*TAG_W    per-bank read data, 1 cycle after a read enable
// BEHAVIOUR
//  - Mapping: bank = set[BNK_W-1:0], address = set[SET_W-1:BNK_W]. Bank b fields sit at slice b of each bus.
//  - Reset values: all tag_mem_* = 0, lkp_ready = upd_ready = 0, rsp_valid = 0, rsp_data = 0, init_done = 0.
//  - FSM: INIT -> RUN. INIT: counter 0..2^SET_PER_BANK_W-1. All banks get chip_en=1, write_en=1, mask all-ones,
//    data_in=0, address=counter each cycle. After the last address, go to RUN the next cycle and set
//    init_done=1. Fill takes exactly 2^SET_PER_BANK_W cycles. ready outputs are 0 in INIT.
//  - RUN, per cycle, combinational grant (ready is a function of valid, set and the fairness bit):
//    * Different banks: both granted in the same cycle.
//    * Same bank: one winner. Per-bank prio bit; 0 = update wins. The winner flips prio to favour the loser.
//      No request waits more than 1 cycle after a conflict.
//    * Single requester: always granted.
//  - Update grant: chip_en=1, write_en=1, mask=upd_way_mask, data_in=upd_data on the target bank.
//    A mask of 0 is accepted and drives no chip_en.
//  - Lookup grant: chip_en=1, write_en=0 on the target bank. The bank index is registered.
//    The next cycle, rsp_valid=1 and rsp_data = tag_mem_data_out slice of that bank, presented combinationally.
//    Fixed latency is 1 cycle from accept to rsp_valid; back-to-back lookups produce back-to-back rsp.
//  - An update to set S accepted in cycle N, followed by a lookup to S in cycle N+1 or later, returns the new data.
//    No internal bypass is needed because the SRAM writes at the edge.
//  - Non-granted banks drive chip_en=0. Their other fields are don't-care, but driven 0.
//  - reset asserted mid-INIT or mid-RUN: the next cycle returns to reset values and INIT restarts at address 0.
//    An in-flight rsp is dropped.
// STRUCTURE
//  - ccp_tag_pkg: typedef tag_way_t [TAG_W], tag_set_t [N_WAYS], fsm_e {INIT,RUN}, and bank/address extract functions.
//  - Sub-module ccp_tag_bank_arb_slice, one per bank: conflict grant plus prio bit.
//  - Top level: INIT counter/FSM, output muxing, read-return register.
// TESTING (N_SETS=1024, N_TAG_BANKS=2, N_WAYS=2)
//  - Reset release -> 512 cycles of all-bank writes, addresses 0..511, data 0; init_done=1 in cycle 513; ready=0 until then.
//  - Update set 7 (bank1, addr 3), mask 2'b01, data 25'h1ABCDEF, then lookup set 7 next cycle
//    -> rsp_valid 1 cycle later, way0 = 25'h1ABCDEF, way1 = 0.
//  - Same-cycle lkp_set=4 and upd_set=6 (both bank0), held valid -> update granted first, lookup next cycle;
//    repeat the conflict -> lookup wins.
//  - Same-cycle lkp_set=4 (bank0) and upd_set=5 (bank1) -> both ready=1; chip_en=2'b11, write_en=2'b10.
//  - 4 back-to-back lookups to sets 0,1,2,3 -> rsp_valid high 4 consecutive cycles, in order.
//  - reset asserted at INIT address 200 -> next fill restarts at address 0; update with mask 0 -> upd_ready=1, chip_en=0.

Source files
------------

// File: rtl/ccp_tag_pkg.sv
// Shared types and helpers for the CCP tag-bank arbiter.
// Holds the default geometry, per-way/per-set tag types, the arbiter FSM
// encoding and the set -> (bank, bank address) mapping helpers.
package ccp_tag_pkg;

    localparam int unsigned DEF_N_SETS      = 1024;
    localparam int unsigned DEF_N_TAG_BANKS = 2;
    localparam int unsigned DEF_N_WAYS      = 2;
    localparam int unsigned DEF_TAG_W       = 25;

    typedef logic [DEF_TAG_W-1:0]            tag_way_t;
    typedef tag_way_t [DEF_N_WAYS-1:0]       tag_set_t;

    typedef enum logic {
        INIT,
        RUN
    } fsm_e;

    // Bank count is a power of two, so these reduce to bit slices of the set index:
    // low bits pick the bank, the remaining high bits are the in-bank address.
    function automatic int unsigned set_bank(input int unsigned set_idx,
                                             input int unsigned n_banks);
        return set_idx % n_banks;
    endfunction

    function automatic int unsigned set_addr(input int unsigned set_idx,
                                             input int unsigned n_banks);
        return set_idx / n_banks;
    endfunction

endpackage

// File: rtl/ccp_tag_bank_arb_slice.sv
// Per-bank conflict arbiter for the CCP tag banks.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   lkp_req/upd_req  lookup / update targeting this bank this cycle
//   lkp_gnt/upd_gnt  combinational grants
// A lone requester is always granted. On a conflict the prio bit picks the
// winner (0 = update) and then flips so the loser wins the next conflict.
module ccp_tag_bank_arb_slice (
    input  logic clk,
    input  logic reset,
    input  logic lkp_req,
    input  logic upd_req,
    output logic lkp_gnt,
    output logic upd_gnt
);

    logic prio_q;
    logic conflict;

    always_comb begin
        conflict = lkp_req && upd_req;
        lkp_gnt  = lkp_req && (!upd_req || prio_q);
        upd_gnt  = upd_req && (!lkp_req || !prio_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (conflict) begin
            prio_q <= ~prio_q;
        end
    end

endmodule

// File: rtl/ccp_tag_bank_arbiter.sv
// Shares the banked CCP tag SRAMs between a lookup (read) and an update (write) port.
// After reset every bank is zero-filled (all addresses, all ways) before traffic is
// accepted. In RUN each bank is arbitrated independently; lookups return data one
// cycle after acceptance, taken straight from the SRAM read port of the registered bank.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   lkp_valid/lkp_ready/lkp_set   lookup request handshake and set index
//   rsp_valid/rsp_data            lookup response (all ways), no backpressure
//   upd_valid/upd_ready/upd_set   update request handshake and set index
//   upd_way_mask/upd_data         ways to write and per-way write data
//   init_done                     zero-fill finished
//   tag_mem_*                     per-bank SRAM controls, bank b at slice b
//   tag_mem_data_out              per-bank SRAM read data, 1 cycle after a read
module ccp_tag_bank_arbiter
    import ccp_tag_pkg::*;
#(
    parameter int unsigned N_SETS      = DEF_N_SETS,
    parameter int unsigned N_TAG_BANKS = DEF_N_TAG_BANKS,
    parameter int unsigned N_WAYS      = DEF_N_WAYS,
    parameter int unsigned TAG_W       = DEF_TAG_W,
    localparam int unsigned SET_W          = $clog2(N_SETS),
    localparam int unsigned BNK_W          = $clog2(N_TAG_BANKS),
    localparam int unsigned SET_PER_BANK_W = $clog2(N_SETS / N_TAG_BANKS),
    localparam int unsigned SET_DATA_W     = N_WAYS * TAG_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 lkp_valid,
    output logic                                 lkp_ready,
    input  logic [SET_W-1:0]                     lkp_set,
    output logic                                 rsp_valid,
    output logic [SET_DATA_W-1:0]                rsp_data,
    input  logic                                 upd_valid,
    output logic                                 upd_ready,
    input  logic [SET_W-1:0]                     upd_set,
    input  logic [N_WAYS-1:0]                    upd_way_mask,
    input  logic [SET_DATA_W-1:0]                upd_data,
    output logic                                 init_done,
    output logic [N_TAG_BANKS-1:0]               tag_mem_chip_en,
    output logic [N_TAG_BANKS-1:0]               tag_mem_write_en,
    output logic [N_TAG_BANKS*N_WAYS-1:0]        tag_mem_write_en_mask,
    output logic [N_TAG_BANKS*SET_PER_BANK_W-1:0] tag_mem_address,
    output logic [N_TAG_BANKS*SET_DATA_W-1:0]    tag_mem_data_in,
    input  logic [N_TAG_BANKS*SET_DATA_W-1:0]    tag_mem_data_out
);

    // Keeps the bank-index registers at least one bit wide for single-bank builds.
    localparam int unsigned BNK_IDX_W = (BNK_W == 0) ? 1 : BNK_W;

    fsm_e                      state_q, state_d;
    logic [SET_PER_BANK_W-1:0] fill_cnt_q, fill_cnt_d;
    logic                      rsp_pend_q;
    logic [BNK_IDX_W-1:0]      rsp_bank_q;

    logic                      live, fill, run;
    logic [BNK_IDX_W-1:0]      lkp_bank, upd_bank;
    logic [SET_PER_BANK_W-1:0] lkp_addr, upd_addr;
    logic [N_TAG_BANKS-1:0]    lkp_req, upd_req, lkp_gnt, upd_gnt;

    // Outputs are forced to their reset values while reset is held, so the fill
    // starts at address 0 in the first cycle reset is low.
    assign live = ~reset;
    assign fill = live && (state_q == INIT);
    assign run  = live && (state_q == RUN);

    assign lkp_bank = BNK_IDX_W'(set_bank(32'(lkp_set), N_TAG_BANKS));
    assign upd_bank = BNK_IDX_W'(set_bank(32'(upd_set), N_TAG_BANKS));
    assign lkp_addr = SET_PER_BANK_W'(set_addr(32'(lkp_set), N_TAG_BANKS));
    assign upd_addr = SET_PER_BANK_W'(set_addr(32'(upd_set), N_TAG_BANKS));

    assign lkp_req = (run && lkp_valid) ? (N_TAG_BANKS'(1) << lkp_bank) : '0;
    assign upd_req = (run && upd_valid) ? (N_TAG_BANKS'(1) << upd_bank) : '0;

    for (genvar b = 0; b < N_TAG_BANKS; b++) begin : g_bank
        ccp_tag_bank_arb_slice u_slice (
            .clk     (clk),
            .reset   (reset),
            .lkp_req (lkp_req[b]),
            .upd_req (upd_req[b]),
            .lkp_gnt (lkp_gnt[b]),
            .upd_gnt (upd_gnt[b])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Next state: one fill address per cycle, RUN after the last one.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (state_q == INIT) begin
            fill_cnt_d = fill_cnt_q + SET_PER_BANK_W'(1);
            if (fill_cnt_q == '1) begin
                state_d = RUN;
            end
        end
    end

    // Outputs
    always_comb begin
        tag_mem_chip_en       = '0;
        tag_mem_write_en      = '0;
        tag_mem_write_en_mask = '0;
        tag_mem_address       = '0;
        tag_mem_data_in       = '0;
        for (int b = 0; b < N_TAG_BANKS; b++) begin
            if (fill) begin
                tag_mem_chip_en[b]                                     = 1'b1;
                tag_mem_write_en[b]                                    = 1'b1;
                tag_mem_write_en_mask[b*N_WAYS +: N_WAYS]              = '1;
                tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W]    = fill_cnt_q;
            end else if (upd_gnt[b] && (|upd_way_mask)) begin
                // An all-zero mask is still accepted but leaves the bank idle.
                tag_mem_chip_en[b]                                     = 1'b1;
                tag_mem_write_en[b]                                    = 1'b1;
                tag_mem_write_en_mask[b*N_WAYS +: N_WAYS]              = upd_way_mask;
                tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W]    = upd_addr;
                tag_mem_data_in[b*SET_DATA_W +: SET_DATA_W]            = upd_data;
            end else if (lkp_gnt[b]) begin
                tag_mem_chip_en[b]                                     = 1'b1;
                tag_mem_address[b*SET_PER_BANK_W +: SET_PER_BANK_W]    = lkp_addr;
            end
        end

        lkp_ready = |lkp_gnt;
        upd_ready = |upd_gnt;
        init_done = run;
        rsp_valid = live && rsp_pend_q;
        rsp_data  = rsp_valid ? tag_mem_data_out[rsp_bank_q*SET_DATA_W +: SET_DATA_W] : '0;
    end

    // Read return: remember which bank's read port holds the accepted lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pend_q <= 1'b0;
            rsp_bank_q <= '0;
        end else begin
            rsp_pend_q <= lkp_ready;
            if (lkp_ready) begin
                rsp_bank_q <= lkp_bank;
            end
        end
    end

endmodule

// File: tb/tb_ccp_tag_bank_arbiter.sv
module tb_ccp_tag_bank_arbiter;
    import ccp_tag_pkg::*;

    localparam int NB    = 2;
    localparam int NW    = 2;
    localparam int TW    = 25;
    localparam int SW    = 10;
    localparam int AW    = 9;
    localparam int NSETS = 1024;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic                  lkp_valid, lkp_ready, upd_valid, upd_ready;
    logic [SW-1:0]         lkp_set, upd_set;
    logic                  rsp_valid, init_done;
    logic [NW*TW-1:0]      rsp_data, upd_data;
    logic [NW-1:0]         upd_way_mask;
    logic [NB-1:0]         ce, we;
    logic [NB*NW-1:0]      wm;
    logic [NB*AW-1:0]      addr;
    logic [NB*NW*TW-1:0]   din, dout;

    ccp_tag_bank_arbiter dut (
        .clk                   (clk),
        .reset                 (reset),
        .lkp_valid             (lkp_valid),
        .lkp_ready             (lkp_ready),
        .lkp_set               (lkp_set),
        .rsp_valid             (rsp_valid),
        .rsp_data              (rsp_data),
        .upd_valid             (upd_valid),
        .upd_ready             (upd_ready),
        .upd_set               (upd_set),
        .upd_way_mask          (upd_way_mask),
        .upd_data              (upd_data),
        .init_done             (init_done),
        .tag_mem_chip_en       (ce),
        .tag_mem_write_en      (we),
        .tag_mem_write_en_mask (wm),
        .tag_mem_address       (addr),
        .tag_mem_data_in       (din),
        .tag_mem_data_out      (dout)
    );

    // SRAM environment: starts with garbage so a missing fill is visible.
    logic [NW*TW-1:0] sram [NB][DEPTH];
    bit sram_init = 1'b0;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < DEPTH; a++)
                    sram[b][a] = {TW'($urandom), TW'($urandom)};
            sram_init = 1'b1;
        end
        for (int b = 0; b < NB; b++) begin
            if (ce[b]) begin
                if (we[b]) begin
                    for (int w = 0; w < NW; w++)
                        if (wm[b*NW+w])
                            sram[b][addr[b*AW +: AW]][w*TW +: TW] = din[(b*NW+w)*TW +: TW];
                end else begin
                    dout[b*NW*TW +: NW*TW] <= sram[b][addr[b*AW +: AW]];
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: set-indexed tag store, fill progress, per-bank fairness bit.
    int       fill_cnt;
    bit       m_run;
    bit       prio [NB];
    bit       pend;
    tag_set_t pend_data;
    tag_set_t ref_mem [NSETS];
    bit       c_lg, c_ug, c_conf;
    int       c_lb;

    task automatic model_check();
        logic [NB-1:0]       e_ce, e_we;
        logic [NB*NW-1:0]    e_wm;
        logic [NB*AW-1:0]    e_addr;
        logic [NB*NW*TW-1:0] e_din;
        bit                  e_id, e_rv;
        tag_set_t            e_rd;
        int                  lb, ub;
        e_ce = '0; e_we = '0; e_wm = '0; e_addr = '0; e_din = '0;
        e_id = 0; e_rv = 0; e_rd = '0;
        c_lg = 0; c_ug = 0; c_conf = 0;
        lb = int'(lkp_set) % NB;
        ub = int'(upd_set) % NB;
        c_lb = lb;
        if (reset) begin
            // everything at reset values
        end else if (!m_run) begin
            e_ce = '1; e_we = '1; e_wm = '1;
            for (int b = 0; b < NB; b++) e_addr[b*AW +: AW] = AW'(fill_cnt);
        end else begin
            e_id   = 1;
            c_conf = lkp_valid && upd_valid && (lb == ub);
            c_lg   = lkp_valid && (!c_conf || prio[lb]);
            c_ug   = upd_valid && (!c_conf || !prio[lb]);
            if (c_ug && upd_way_mask != 0) begin
                e_ce[ub] = 1; e_we[ub] = 1;
                e_wm[ub*NW +: NW]         = upd_way_mask;
                e_addr[ub*AW +: AW]       = AW'(int'(upd_set) / NB);
                e_din[ub*NW*TW +: NW*TW]  = upd_data;
            end
            if (c_lg) begin
                e_ce[lb] = 1;
                e_addr[lb*AW +: AW] = AW'(int'(lkp_set) / NB);
            end
            e_rv = pend;
            e_rd = pend ? pend_data : '0;
        end
        chk("lkp_ready", lkp_ready, c_lg);
        chk("upd_ready", upd_ready, c_ug);
        chk("init_done", init_done, e_id);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("chip_en", ce, e_ce);
        chk("write_en", we, e_we);
        chk("write_en_mask", wm, e_wm);
        chk("address", addr, e_addr);
        chk("data_in", din, e_din);
    endtask

    task automatic model_update();
        if (reset) begin
            fill_cnt = 0; m_run = 0; pend = 0;
            for (int b = 0; b < NB; b++) prio[b] = 0;
            for (int s = 0; s < NSETS; s++) ref_mem[s] = '0;
        end else if (!m_run) begin
            fill_cnt++;
            if (fill_cnt == DEPTH) m_run = 1;
        end else begin
            if (c_conf) prio[c_lb] = !prio[c_lb];
            pend = c_lg;
            if (c_lg) pend_data = ref_mem[lkp_set];
            if (c_ug)
                for (int w = 0; w < NW; w++)
                    if (upd_way_mask[w]) ref_mem[upd_set][w] = upd_data[w*TW +: TW];
        end
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        lkp_valid = 0;
        upd_valid = 0;
    endtask

    function automatic logic [SW-1:0] pick_set();
        if ($urandom_range(0, 1) == 1) return SW'($urandom_range(0, 15));
        return SW'($urandom_range(0, NSETS - 1));
    endfunction

    task automatic rand_step();
        lkp_valid    = ($urandom_range(0, 2) != 0);
        lkp_set      = pick_set();
        upd_valid    = ($urandom_range(0, 2) != 0);
        upd_set      = pick_set();
        upd_way_mask = NW'($urandom_range(0, 3));
        upd_data     = {TW'($urandom), TW'($urandom)};
        step();
    endtask

    int fill_seen;

    initial begin
        reset = 1; idle();
        lkp_set = '0; upd_set = '0; upd_way_mask = '0; upd_data = '0;
        @(negedge clk);
        repeat (3) step();
        reset = 0;

        // Zero-fill: 512 all-bank write cycles, then init_done.
        fill_seen = 0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            if (ce == 2'b11 && we == 2'b11 && wm == 4'b1111 && din == '0 &&
                addr == {AW'(i), AW'(i)} && !init_done && !lkp_ready)
                fill_seen++;
            step();
        end
        chk("fill_cycles", fill_seen, DEPTH);
        #1 chk("init_done_after_fill", init_done, 1'b1);

        // Update set 7 way0, then lookup it.
        upd_valid = 1; upd_set = 7; upd_way_mask = 2'b01;
        upd_data = {25'h0155555, 25'h1ABCDEF};
        #1;
        chk("d1_upd_ready", upd_ready, 1'b1);
        chk("d1_chip_en", ce, 2'b10);
        chk("d1_wmask", wm, 4'b0100);
        chk("d1_bank1_addr", addr[AW +: AW], 9'd3);
        step();
        upd_valid = 0; lkp_valid = 1; lkp_set = 7;
        #1 chk("d1_lkp_ready", lkp_ready, 1'b1);
        step();
        idle();
        #1;
        chk("d1_rsp_valid", rsp_valid, 1'b1);
        chk("d1_rsp_data", rsp_data, {25'h0, 25'h1ABCDEF});
        step();

        // Same-bank conflict twice: update first, then lookup.
        lkp_valid = 1; lkp_set = 4; upd_valid = 1; upd_set = 6; upd_way_mask = 2'b11;
        upd_data = {25'h0000AAA, 25'h0000BBB};
        #1;
        chk("d2_first_upd", upd_ready, 1'b1);
        chk("d2_first_lkp", lkp_ready, 1'b0);
        step();
        upd_valid = 0;
        #1 chk("d2_lkp_next", lkp_ready, 1'b1);
        step();
        upd_valid = 1;
        #1;
        chk("d2_again_lkp", lkp_ready, 1'b1);
        chk("d2_again_upd", upd_ready, 1'b0);
        step();
        lkp_valid = 0;
        #1 chk("d2_upd_next", upd_ready, 1'b1);
        step();

        // Different banks in parallel.
        lkp_valid = 1; lkp_set = 4; upd_valid = 1; upd_set = 5; upd_way_mask = 2'b11;
        #1;
        chk("d3_lkp_ready", lkp_ready, 1'b1);
        chk("d3_upd_ready", upd_ready, 1'b1);
        chk("d3_chip_en", ce, 2'b11);
        chk("d3_write_en", we, 2'b10);
        step();
        idle();

        // Back-to-back lookups of sets 0..3 after writing distinct data.
        for (int i = 0; i < 4; i++) begin
            upd_valid = 1; upd_set = SW'(i); upd_way_mask = 2'b11;
            upd_data = {25'(i + 32), 25'(i + 16)};
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            lkp_valid = (i < 4);
            lkp_set   = SW'(i % 4);
            #1;
            if (i > 0) begin
                chk("d4_rsp_valid", rsp_valid, 1'b1);
                chk("d4_rsp_data", rsp_data, {25'(i + 31), 25'(i + 15)});
            end
            step();
        end

        // Zero-mask update.
        upd_valid = 1; upd_set = 9; upd_way_mask = 2'b00;
        #1;
        chk("d5_upd_ready", upd_ready, 1'b1);
        chk("d5_chip_en", ce, 2'b00);
        step();
        idle();

        repeat (2000) rand_step();

        // Reset with a lookup in flight drops the response.
        idle(); lkp_valid = 1; lkp_set = 3;
        step();
        idle(); reset = 1;
        #1 chk("rst_drop_rsp", rsp_valid, 1'b0);
        step();
        reset = 0;
        repeat (200) step();
        #1 chk("fill_at_200", addr[AW-1:0], 9'd200);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("fill_restart_addr", addr, 18'd0);
        chk("fill_restart_ce", ce, 2'b11);
        repeat (DEPTH) step();

        repeat (500) rand_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
